// File: rtl/mem_cache_controller_pkg.sv
// Shared definitions for the data cache controller.
// Provides the controller state encoding, the data word width and helpers
// that derive address-field widths from the cache geometry parameters.
package mem_cache_controller_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  // Bits selecting a word inside a line (0 when a line is a single word).
  function automatic int unsigned off_bits(input int unsigned wpl);
    return $clog2(wpl);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Everything above the byte, word-offset and index fields.
  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned sets,
                                           input int unsigned wpl);
    return addr_w - 2 - off_bits(wpl) - idx_bits(sets);
  endfunction

endpackage

// File: rtl/mem_cache_controller_plru.sv
// plru_tree: tree pseudo-LRU helper for one cache set.
// Ports:
//   i_plru   - current PLRU bits of the set
//   i_way    - way being accessed (hit or fill)
//   o_next   - PLRU bits after the access to i_way
//   o_victim - way the current PLRU bits point at for replacement
// Each tree bit names the side holding the victim; an access flips the
// bits on its path to point away from the accessed way.
module plru_tree #(
  parameter int unsigned WAYS = 2,
  localparam int unsigned PW = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PW-1:0] i_plru,
  input  logic [WW-1:0] i_way,
  output logic [PW-1:0] o_next,
  output logic [WW-1:0] o_victim
);

  if (WAYS == 4) begin : g_w4
    // bit0: root (0 = pair {0,1}, 1 = pair {2,3}); bit1/bit2: way in pair
    assign o_victim = i_plru[0] ? {1'b1, i_plru[2]} : {1'b0, i_plru[1]};

    always_comb begin
      o_next    = i_plru;
      o_next[0] = ~i_way[1];
      if (i_way[1]) o_next[2] = ~i_way[0];
      else          o_next[1] = ~i_way[0];
    end
  end else if (WAYS == 2) begin : g_w2
    assign o_victim = i_plru;
    assign o_next   = ~i_way;
  end else begin : g_w1
    logic w_unused;
    assign w_unused = ^{i_plru, i_way};
    assign o_victim = '0;
    assign o_next   = '0;
  end

endmodule

// File: rtl/mem_cache_controller.sv
// mem_cache_controller: set-associative, write-through, no-write-allocate
// data cache between the MEM stage and the external SRAM port.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   rd_en, wr_en, addr  - MEM-stage load/store request (store wins if both)
//   wdata               - store data
//   invalidate          - clear all valid bits (deferred until idle)
//   rdata, ready        - load data / request complete (combinational)
//   sram_rd_req/wr_req  - registered line-fill / word-write requests
//   sram_addr/wdata     - registered SRAM address / write data
//   sram_rdata          - fill line, word 0 in the LSBs
//   sram_ack            - one-cycle SRAM completion pulse
module mem_cache_controller
  import mem_cache_controller_pkg::*;
#(
  parameter int unsigned SETS           = 64,
  parameter int unsigned WAYS           = 2,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [31:0]                wdata,
  input  logic                       invalidate,
  output logic [31:0]                rdata,
  output logic                       ready,
  output logic                       sram_rd_req,
  output logic                       sram_wr_req,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic [31:0]                sram_wdata,
  input  logic [32*WORDS_PER_LINE-1:0] sram_rdata,
  input  logic                       sram_ack
);

  localparam int unsigned OFF_BITS = off_bits(WORDS_PER_LINE);
  localparam int unsigned IDX_W    = idx_bits(SETS);
  localparam int unsigned TAG_W    = tag_bits(ADDR_W, SETS, WORDS_PER_LINE);
  localparam int unsigned OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int unsigned LINE_SH  = 2 + OFF_BITS;
  localparam int unsigned PW       = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int unsigned WW       = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Cache storage
  logic              r_valid    [SETS][WAYS];
  logic [TAG_W-1:0]  r_tag_mem  [SETS][WAYS];
  logic [WORD_W-1:0] r_data     [SETS][WAYS][WORDS_PER_LINE];
  logic [PW-1:0]     r_plru     [SETS];

  // Controller state and latched miss request
  state_t            r_state;
  logic              r_sram_rd_req, r_sram_wr_req;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [31:0]       r_sram_wdata;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_miss_tag;
  logic [OFF_W-1:0]  r_off;
  logic              r_inv_pend;

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit, w_inv_found, w_req, w_rd_hit;
  logic [WW-1:0]     w_hit_way, w_inv_way, w_victim, w_plru_victim;
  logic [WW-1:0]     w_unused_hit_victim;
  logic [PW-1:0]     w_plru_hit_next, w_plru_fill_next;
  logic [WORD_W-1:0] w_fill_word;
  logic              w_unused_addr;

  assign w_unused_addr = ^addr[1:0];
  assign w_off    = OFF_W'((addr >> 2) & ADDR_W'(WORDS_PER_LINE - 1));
  assign w_idx    = IDX_W'(addr >> LINE_SH);
  assign w_tag    = TAG_W'(addr >> (LINE_SH + IDX_W));
  assign w_req    = rd_en | wr_en;
  assign w_rd_hit = rd_en & ~wr_en & w_hit;
  assign w_fill_word = sram_rdata[WORD_W*int'(r_off) +: WORD_W];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_idx][i] && r_tag_mem[w_idx][i] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(i);
      end
    end
  end

  // Victim: lowest invalid way in the missed set, else the PLRU choice
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_inv_found && !r_valid[r_idx][i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WW'(i);
      end
    end
    w_victim = w_inv_found ? w_inv_way : w_plru_victim;
  end

  plru_tree #(.WAYS(WAYS)) u_plru_hit (
    .i_plru   (r_plru[w_idx]),
    .i_way    (w_hit_way),
    .o_next   (w_plru_hit_next),
    .o_victim (w_unused_hit_victim)
  );

  plru_tree #(.WAYS(WAYS)) u_plru_fill (
    .i_plru   (r_plru[r_idx]),
    .i_way    (w_victim),
    .o_next   (w_plru_fill_next),
    .o_victim (w_plru_victim)
  );

  always_comb begin
    ready = 1'b0;
    rdata = '0;
    case (r_state)
      IDLE: begin
        ready = ~w_req | w_rd_hit;
        if (w_rd_hit) rdata = r_data[w_idx][w_hit_way][w_off];
      end
      RD_MISS: begin
        ready = sram_ack;
        if (sram_ack) rdata = w_fill_word;
      end
      WR_THRU: ready = sram_ack;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sram_rd_req <= 1'b0;
      r_sram_wr_req <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_wdata  <= '0;
      r_idx         <= '0;
      r_miss_tag    <= '0;
      r_off         <= '0;
      r_inv_pend    <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_en) begin
            r_inv_pend    <= r_inv_pend | invalidate;
            r_sram_wr_req <= 1'b1;
            r_sram_addr   <= {addr[ADDR_W-1:2], 2'b00};
            r_sram_wdata  <= wdata;
            r_state       <= WR_THRU;
            if (w_hit) r_plru[w_idx] <= w_plru_hit_next;
          end else if (rd_en) begin
            r_inv_pend <= r_inv_pend | invalidate;
            if (w_hit) begin
              r_plru[w_idx] <= w_plru_hit_next;
            end else begin
              r_sram_rd_req <= 1'b1;
              r_sram_addr   <= (addr >> LINE_SH) << LINE_SH;
              r_idx         <= w_idx;
              r_miss_tag    <= w_tag;
              r_off         <= w_off;
              r_state       <= RD_MISS;
            end
          end else if (invalidate || r_inv_pend) begin
            r_inv_pend <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
              r_plru[s] <= '0;
              for (int unsigned w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
            end
          end
        end
        RD_MISS: begin
          r_inv_pend <= r_inv_pend | invalidate;
          if (sram_ack) begin
            r_sram_rd_req            <= 1'b0;
            r_valid[r_idx][w_victim] <= 1'b1;
            r_plru[r_idx]            <= w_plru_fill_next;
            r_state                  <= IDLE;
          end
        end
        WR_THRU: begin
          r_inv_pend <= r_inv_pend | invalidate;
          if (sram_ack) begin
            r_sram_wr_req <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits alone qualify their contents
  always_ff @(posedge clk) begin
    if (r_state == IDLE && wr_en && w_hit)
      r_data[w_idx][w_hit_way][w_off] <= wdata;
    if (r_state == RD_MISS && sram_ack) begin
      r_tag_mem[r_idx][w_victim] <= r_miss_tag;
      for (int unsigned k = 0; k < WORDS_PER_LINE; k++)
        r_data[r_idx][w_victim][k] <= sram_rdata[WORD_W*k +: WORD_W];
    end
  end

  assign sram_rd_req = r_sram_rd_req;
  assign sram_wr_req = r_sram_wr_req;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;

endmodule

// File: tb/tb_mem_cache_controller.sv
// Directed testbench for mem_cache_controller (SETS=64, WAYS=2, WPL=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further 2 units later, well away from either clock edge.
module tb_mem_cache_controller;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, invalidate, sram_ack;
  logic [31:0] addr, wdata, rdata, sram_addr, sram_wdata;
  logic        ready, sram_rd_req, sram_wr_req;
  logic [63:0] sram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_cache_controller #(
    .SETS(64), .WAYS(2), .WORDS_PER_LINE(2), .ADDR_W(32)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .invalidate(invalidate), .rdata(rdata), .ready(ready),
    .sram_rd_req(sram_rd_req), .sram_wr_req(sram_wr_req),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 0; wr_en = 0; invalidate = 0; sram_ack = 0;
    sram_rdata = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
  endtask

  // Read miss completed with a one-cycle SRAM latency; no checking here.
  task automatic read_fill(input logic [31:0] a, input logic [63:0] line);
    rd_en = 1; addr = a;
    step();
    sram_ack = 1; sram_rdata = line;
    step();
    sram_ack = 0; rd_en = 0; sram_rdata = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL reset_rd_req: got %0b exp 0", sram_rd_req); end
    checks++; if (sram_wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req: got %0b exp 0", sram_wr_req); end
    checks++; if (sram_addr !== 32'h0) begin failures++; $display("FAIL reset_sram_addr: got %h exp 0", sram_addr); end
    checks++; if (sram_wdata !== 32'h0) begin failures++; $display("FAIL reset_sram_wdata: got %h exp 0", sram_wdata); end
    step();
  endtask

  task automatic test_cold_read();
    do_reset();
    rd_en = 1; addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL cold_wait_ready[%0d]: got %0b exp 0", i, ready); end
      if (i > 0) begin
        checks++; if (sram_rd_req !== 1'b1) begin failures++; $display("FAIL cold_rd_req[%0d]: got %0b exp 1", i, sram_rd_req); end
        checks++; if (sram_addr !== 32'h100) begin failures++; $display("FAIL cold_sram_addr[%0d]: got %h exp 100", i, sram_addr); end
      end
      step();
    end
    sram_ack = 1; sram_rdata = {32'hBBBB0002, 32'hAAAA0001};
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL cold_ack_ready: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'hAAAA0001) begin failures++; $display("FAIL cold_ack_rdata: got %h exp AAAA0001", rdata); end
    step();
    sram_ack = 0; sram_rdata = '0; addr = 32'h104;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reread_ready: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'hBBBB0002) begin failures++; $display("FAIL reread_rdata: got %h exp BBBB0002", rdata); end
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL reread_rd_req: got %0b exp 0", sram_rd_req); end
    rd_en = 0;
    step();
  endtask

  // Relies on the line at 0x100 filled by test_cold_read.
  task automatic test_write_hit();
    wr_en = 1; addr = 32'h100; wdata = 32'h12345678;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wh_req_ready: got %0b exp 0", ready); end
    step();
    #2;
    checks++; if (sram_wr_req !== 1'b1) begin failures++; $display("FAIL wh_wr_req: got %0b exp 1", sram_wr_req); end
    checks++; if (sram_addr !== 32'h100) begin failures++; $display("FAIL wh_sram_addr: got %h exp 100", sram_addr); end
    checks++; if (sram_wdata !== 32'h12345678) begin failures++; $display("FAIL wh_sram_wdata: got %h exp 12345678", sram_wdata); end
    step();
    #2;
    checks++; if (sram_wr_req !== 1'b1) begin failures++; $display("FAIL wh_wr_req_hold: got %0b exp 1", sram_wr_req); end
    sram_ack = 1;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wh_ack_ready: got %0b exp 1", ready); end
    step();
    sram_ack = 0; wr_en = 0; rd_en = 1; addr = 32'h100;
    #2;
    checks++; if (sram_wr_req !== 1'b0) begin failures++; $display("FAIL wh_wr_req_drop: got %0b exp 0", sram_wr_req); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wh_read_ready: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'h12345678) begin failures++; $display("FAIL wh_read_rdata: got %h exp 12345678", rdata); end
    rd_en = 0;
    step();
  endtask

  task automatic test_write_miss();
    wr_en = 1; addr = 32'h4000; wdata = 32'h5;
    step();
    #2;
    checks++; if (sram_wr_req !== 1'b1) begin failures++; $display("FAIL wm_wr_req: got %0b exp 1", sram_wr_req); end
    checks++; if (sram_addr !== 32'h4000) begin failures++; $display("FAIL wm_sram_addr: got %h exp 4000", sram_addr); end
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL wm_rd_req: got %0b exp 0", sram_rd_req); end
    sram_ack = 1;
    step();
    sram_ack = 0; wr_en = 0; rd_en = 1; addr = 32'h4000;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wm_read_ready: got %0b exp 0", ready); end
    step();
    #2;
    checks++; if (sram_rd_req !== 1'b1) begin failures++; $display("FAIL wm_read_rd_req: got %0b exp 1", sram_rd_req); end
    checks++; if (sram_addr !== 32'h4000) begin failures++; $display("FAIL wm_read_addr: got %h exp 4000", sram_addr); end
    sram_ack = 1; sram_rdata = {32'h0, 32'h5};
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_rw_both();
    do_reset();
    rd_en = 1; wr_en = 1; addr = 32'h10; wdata = 32'h77;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rw_ready: got %0b exp 0", ready); end
    step();
    #2;
    checks++; if (sram_wr_req !== 1'b1) begin failures++; $display("FAIL rw_wr_req: got %0b exp 1", sram_wr_req); end
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL rw_rd_req: got %0b exp 0", sram_rd_req); end
    sram_ack = 1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_plru();
    do_reset();
    read_fill(32'h000, {32'hA001, 32'hA000});
    read_fill(32'h200, {32'hB001, 32'hB000});
    rd_en = 1; addr = 32'h000;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL plru_a_touch: got %0b exp 1", ready); end
    step();
    rd_en = 0;
    read_fill(32'h400, {32'hC001, 32'hC000});
    // Probes drop rd_en before the edge so they leave no state behind.
    rd_en = 1; addr = 32'h000;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL plru_a_hit: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'hA000) begin failures++; $display("FAIL plru_a_rdata: got %h exp A000", rdata); end
    addr = 32'h404;
    #2;
    checks++; if (rdata !== 32'hC001) begin failures++; $display("FAIL plru_c_rdata: got %h exp C001", rdata); end
    addr = 32'h200;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL plru_b_evicted: got %0b exp 0", ready); end
    rd_en = 0;
    step();
  endtask

  task automatic test_invalidate();
    do_reset();
    read_fill(32'h000, {32'hA001, 32'hA000});
    rd_en = 1; addr = 32'h800;
    step();
    invalidate = 1;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL inv_miss_ready: got %0b exp 0", ready); end
    step();
    invalidate = 0; sram_ack = 1; sram_rdata = {32'hD001, 32'hD000};
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL inv_ack_ready: got %0b exp 1", ready); end
    checks++; if (rdata !== 32'hD000) begin failures++; $display("FAIL inv_ack_rdata: got %h exp D000", rdata); end
    step();
    sram_ack = 0; sram_rdata = '0;
    #2;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL inv_fill_hit: got %0b exp 1", ready); end
    rd_en = 0;
    step();
    rd_en = 1; addr = 32'h800;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL inv_cleared_800: got %0b exp 0", ready); end
    addr = 32'h000;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL inv_cleared_000: got %0b exp 0", ready); end
    rd_en = 0;
    step();
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    rd_en = 1; addr = 32'h300;
    step();
    #2;
    checks++; if (sram_rd_req !== 1'b1) begin failures++; $display("FAIL rmm_rd_req: got %0b exp 1", sram_rd_req); end
    rst = 1; rd_en = 0;
    #1;
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL rmm_req_drop: got %0b exp 0", sram_rd_req); end
    checks++; if (sram_addr !== 32'h0) begin failures++; $display("FAIL rmm_addr_clr: got %h exp 0", sram_addr); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rmm_ready: got %0b exp 1", ready); end
    step();
    rst = 0; sram_ack = 1; sram_rdata = {32'hE001, 32'hE000};
    step();
    sram_ack = 0; sram_rdata = '0;
    #2;
    checks++; if (sram_rd_req !== 1'b0) begin failures++; $display("FAIL rmm_late_ack_rd: got %0b exp 0", sram_rd_req); end
    rd_en = 1; addr = 32'h300;
    #2;
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rmm_not_filled: got %0b exp 0", ready); end
    rd_en = 0;
    step();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_cold_read();
    test_write_hit();
    test_write_miss();
    test_rw_both();
    test_plru();
    test_invalidate();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
